// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button press-event controller:
//   - cls_state_e : classifier state encoding (3 bits)
//   - DEF_*       : default cycle constants and counter width used as
//                   parameter defaults by btn_debounce and button_event_ctrl
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        CLS_IDLE  = 3'd0,
        CLS_HELD  = 3'd1,
        CLS_LONG  = 3'd2,
        CLS_GAP   = 3'd3,
        CLS_HELD2 = 3'd4
    } cls_state_e;

    localparam int DEF_DEBOUNCE_CYCLES   = 1000;
    localparam int DEF_LONG_CYCLES       = 50000;
    localparam int DEF_DOUBLE_GAP_CYCLES = 20000;
    localparam int DEF_CNT_W             = 16;

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Debounces an already-synchronized button level. The debounced level only
// changes after DEBOUNCE_CYCLES consecutive samples that differ from it, and
// the matching press/release pulse is raised in the same cycle the new level
// first becomes visible.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   btn_sync      in   synchronized raw button level (1 = pressed)
//   btn_state     out  debounced button level
//   press_pulse   out  one-cycle pulse on btn_state 0->1
//   release_pulse out  one-cycle pulse on btn_state 1->0
// ----------------------------------------------------------------------------
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_sync,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             state_q, state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Any sample that agrees with the debounced level restarts the run, so
    // only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
    always_comb begin
        db_cnt_d  = '0;
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (btn_sync != state_q) begin
            if (db_cnt_q == DB_LAST) begin
                state_d   = ~state_q;
                press_d   = ~state_q;
                release_d = state_q;
            end else begin
                db_cnt_d = db_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q  <= '0;
            state_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_state     = state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/button_event_ctrl.sv
// ----------------------------------------------------------------------------
// button_event_ctrl
// Debounces a synchronized button and classifies activity into single-cycle
// short, long and double press events. The classifier reacts to the
// debounced press/release pulses registered in the previous cycle.
// Legal ranges: DEBOUNCE_CYCLES, LONG_CYCLES, DOUBLE_GAP_CYCLES >= 2, and
// CNT_W wide enough to hold the largest of them.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   btn_sync      in   synchronized button level (1 = pressed)
//   enable        in   1 = classification active, 0 = classifier held idle
//   btn_state     out  debounced button level
//   press_pulse   out  one-cycle pulse on btn_state 0->1
//   release_pulse out  one-cycle pulse on btn_state 1->0
//   short_pulse   out  single press released before long, no second press
//   long_pulse    out  press held for LONG_CYCLES
//   double_pulse  out  second press began within the release gap
//   busy          out  classifier is not idle
// ----------------------------------------------------------------------------
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES       = DEF_LONG_CYCLES,
    parameter int DOUBLE_GAP_CYCLES = DEF_DOUBLE_GAP_CYCLES,
    parameter int CNT_W             = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_sync,
    input  logic enable,
    output logic btn_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic busy
);

    // Thresholds are compared against the count before it increments, so the
    // event is registered on the edge where the count would reach N-1. This
    // places long_pulse LONG_CYCLES cycles after press_pulse and short_pulse
    // DOUBLE_GAP_CYCLES cycles after release_pulse.
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_PRE  = CNT_W'(DOUBLE_GAP_CYCLES - 2);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    cls_state_e       state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] gap_cnt_q;
    logic             short_q;
    logic             long_q;
    logic             double_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_sync      (btn_sync),
        .btn_state     (btn_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    // Classifier. Release takes priority over the long threshold in HELD and
    // press takes priority over gap expiry in GAP. Dropping enable abandons
    // whatever episode is in progress; a press already underway when enable
    // returns is ignored because only a fresh press_pulse leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLS_IDLE;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            double_q   <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            if (!enable) begin
                state_q    <= CLS_IDLE;
                hold_cnt_q <= '0;
                gap_cnt_q  <= '0;
            end else begin
                case (state_q)
                    CLS_IDLE: begin
                        if (press_pulse) begin
                            state_q    <= CLS_HELD;
                            hold_cnt_q <= '0;
                        end
                    end
                    CLS_HELD: begin
                        if (release_pulse) begin
                            state_q   <= CLS_GAP;
                            gap_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + ONE;
                            if (hold_cnt_q == LONG_PRE) begin
                                long_q  <= 1'b1;
                                state_q <= CLS_LONG;
                            end
                        end
                    end
                    CLS_LONG: begin
                        if (release_pulse) begin
                            state_q <= CLS_IDLE;
                        end
                    end
                    CLS_GAP: begin
                        if (press_pulse) begin
                            double_q <= 1'b1;
                            state_q  <= CLS_HELD2;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + ONE;
                            if (gap_cnt_q == GAP_PRE) begin
                                short_q <= 1'b1;
                                state_q <= CLS_IDLE;
                            end
                        end
                    end
                    CLS_HELD2: begin
                        if (release_pulse) begin
                            state_q <= CLS_IDLE;
                        end
                    end
                    default: begin
                        state_q <= CLS_IDLE;
                    end
                endcase
            end
        end
    end

    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign double_pulse = double_q;
    assign busy         = (state_q != CLS_IDLE);

endmodule

// File: tb/tb_button_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_button_event_ctrl
// Self-checking bench for button_event_ctrl. Every cycle the DUT outputs are
// compared against a timestamp-based reference model; directed scenarios add
// latency/count checks against fixed constants, followed by a random phase
// with bounces, enable dropouts and mid-run resets.
// ----------------------------------------------------------------------------
module tb_button_event_ctrl;

    localparam int TB_DEB  = 4;
    localparam int TB_LONG = 20;
    localparam int TB_GAP  = 10;
    localparam int TB_CW   = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btnSync = 1'b0;
    logic enable = 1'b0;
    logic btnState, pressPulse, releasePulse;
    logic shortPulse, longPulse, doublePulse, busy;

    button_event_ctrl #(
        .DEBOUNCE_CYCLES   (TB_DEB),
        .LONG_CYCLES       (TB_LONG),
        .DOUBLE_GAP_CYCLES (TB_GAP),
        .CNT_W             (TB_CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_sync      (btnSync),
        .enable        (enable),
        .btn_state     (btnState),
        .press_pulse   (pressPulse),
        .release_pulse (releasePulse),
        .short_pulse   (shortPulse),
        .long_pulse    (longPulse),
        .double_pulse  (doublePulse),
        .busy          (busy)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 0;

    // Reference model: debounced level from the length of the current run of
    // differing samples, and the classifier as an "episode" described by the
    // timestamps of its first press, its release and its second press.
    bit mDbState, mPress, mRelease, mShort, mLong, mDouble, mBusy;
    int mDiffStart;
    bit epActive, epLongDone;
    int epPress, epRelease, epSecond;

    // Observed DUT event timestamps and counts for directed checks
    int obsPressAt, obsReleaseAt, obsShortAt, obsLongAt, obsDoubleAt, obsBusyFallAt;
    int nPress, nRelease, nShort, nLong, nDouble, nBusy, nState;
    bit busyPrev = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic modelReset();
        mDbState = 0; mPress = 0; mRelease = 0;
        mShort = 0; mLong = 0; mDouble = 0; mBusy = 0;
        mDiffStart = -1;
        epActive = 0; epLongDone = 0;
        epPress = -1; epRelease = -1; epSecond = -1;
    endtask

    task automatic modelStep(input logic s, input logic en);
        bit prevP, prevR;
        int now;
        now = cyc;
        prevP = mPress;
        prevR = mRelease;
        mShort = 0; mLong = 0; mDouble = 0;
        if (!en) begin
            epActive = 0;
        end else if (!epActive) begin
            if (prevP) begin
                epActive = 1; epLongDone = 0;
                epPress = now - 1; epRelease = -1; epSecond = -1;
            end
        end else if (epSecond >= 0 || epLongDone) begin
            if (prevR) epActive = 0;
        end else if (epRelease < 0) begin
            if (prevR) epRelease = now - 1;
            else if (now == epPress + TB_LONG) begin
                mLong = 1; epLongDone = 1;
            end
        end else begin
            if (prevP) begin
                mDouble = 1; epSecond = now - 1;
            end else if (now == epRelease + TB_GAP) begin
                mShort = 1; epActive = 0;
            end
        end
        mBusy = epActive;

        mPress = 0; mRelease = 0;
        if (s == mDbState) begin
            mDiffStart = -1;
        end else begin
            if (mDiffStart < 0) mDiffStart = now;
            if (now - mDiffStart + 1 == TB_DEB) begin
                mDbState = ~mDbState;
                mPress = mDbState;
                mRelease = ~mDbState;
                mDiffStart = -1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("btn_state",     btnState,     mDbState);
        checkOutput("press_pulse",   pressPulse,   mPress);
        checkOutput("release_pulse", releasePulse, mRelease);
        checkOutput("short_pulse",   shortPulse,   mShort);
        checkOutput("long_pulse",    longPulse,    mLong);
        checkOutput("double_pulse",  doublePulse,  mDouble);
        checkOutput("busy",          busy,         mBusy);
    endtask

    task automatic clearObs();
        obsPressAt = -1000; obsReleaseAt = -1000; obsShortAt = -1000;
        obsLongAt = -1000; obsDoubleAt = -1000; obsBusyFallAt = -1000;
        nPress = 0; nRelease = 0; nShort = 0; nLong = 0;
        nDouble = 0; nBusy = 0; nState = 0;
    endtask

    task automatic observe();
        if (pressPulse)   begin nPress++;   obsPressAt   = cyc; end
        if (releasePulse) begin nRelease++; obsReleaseAt = cyc; end
        if (shortPulse)   begin nShort++;   obsShortAt   = cyc; end
        if (longPulse)    begin nLong++;    obsLongAt    = cyc; end
        if (doublePulse)  begin nDouble++;  obsDoubleAt  = cyc; end
        if (busy) nBusy++;
        if (btnState) nState++;
        if (busyPrev && !busy) obsBusyFallAt = cyc;
        busyPrev = busy;
    endtask

    // One clock cycle: drive inputs, let the edge happen, check 1 unit later
    task automatic applyStimulus(input logic s, input logic en);
        btnSync = s;
        enable  = en;
        @(posedge clk);
        #1;
        cyc++;
        modelStep(s, en);
        checkAll();
        observe();
    endtask

    // Assert reset mid-cycle, verify outputs clear at once and while held
    task automatic doReset(input int holdCycles);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        repeat (holdCycles) begin
            @(posedge clk);
            #1;
            cyc++;
            checkAll();
        end
        rst_n = 1'b1;
        busyPrev = 1'b0;
    endtask

    initial begin
        logic [6:0] bouncePat;
        int relCyc;
        int riseCyc;
        bit level;
        int segLen;
        bit segEn;
        bit noisy;

        modelReset();
        clearObs();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        rst_n = 1'b1;
        repeat (5) applyStimulus(1'b0, 1'b1);

        $display("[TB] Scenario 1: bounce");
        clearObs();
        bouncePat = 7'b1011010;
        for (int i = 6; i >= 0; i--) applyStimulus(bouncePat[i], 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b1);
        checkOutput("t1_press_count", nPress, 0);
        checkOutput("t1_state_cycles", nState, 0);
        checkOutput("t1_busy_cycles", nBusy, 0);

        $display("[TB] Scenario 2: short press");
        clearObs();
        riseCyc = cyc;
        repeat (8) applyStimulus(1'b1, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b1);
        checkOutput("t2_press_latency", obsPressAt - riseCyc, TB_DEB);
        checkOutput("t2_state_cycles", nState, 8);
        checkOutput("t2_release_after_press", obsReleaseAt - obsPressAt, 8);
        checkOutput("t2_short_after_release", obsShortAt - obsReleaseAt, TB_GAP);
        checkOutput("t2_short_count", nShort, 1);
        checkOutput("t2_long_count", nLong, 0);
        checkOutput("t2_double_count", nDouble, 0);

        $display("[TB] Scenario 3: long press");
        clearObs();
        repeat (30) applyStimulus(1'b1, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b1);
        checkOutput("t3_long_after_press", obsLongAt - obsPressAt, TB_LONG);
        checkOutput("t3_long_count", nLong, 1);
        checkOutput("t3_short_count", nShort, 0);
        checkOutput("t3_busy_fall", obsBusyFallAt - obsReleaseAt, 1);

        $display("[TB] Scenario 4: double press");
        clearObs();
        repeat (6) applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b1);
        checkOutput("t4_press_count", nPress, 2);
        checkOutput("t4_double_count", nDouble, 1);
        checkOutput("t4_double_after_press2", obsDoubleAt - obsPressAt, 1);
        checkOutput("t4_short_count", nShort, 0);
        checkOutput("t4_long_count", nLong, 0);
        checkOutput("t4_busy_fall", obsBusyFallAt - obsReleaseAt, 1);

        $display("[TB] Scenario 5: enable low");
        clearObs();
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (8) applyStimulus(1'b1, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0);
        checkOutput("t5_press_count", nPress, 1);
        checkOutput("t5_release_count", nRelease, 1);
        checkOutput("t5_event_count", nShort + nLong + nDouble, 0);
        checkOutput("t5_busy_cycles", nBusy, 0);
        repeat (3) applyStimulus(1'b0, 1'b1);

        $display("[TB] Scenario 6: reset mid-press");
        clearObs();
        for (int i = 0; i < 10 && nPress == 0; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("t6_first_press", nPress, 1);
        repeat (10) applyStimulus(1'b1, 1'b1);
        checkOutput("t6_busy_before_reset", busy, 1);
        doReset(2);
        checkOutput("t6_busy_in_reset", busy, 0);
        clearObs();
        relCyc = cyc;
        repeat (30) applyStimulus(1'b1, 1'b1);
        checkOutput("t6_press_latency", obsPressAt - relCyc, TB_DEB);
        checkOutput("t6_long_after_press", obsLongAt - obsPressAt, TB_LONG);
        checkOutput("t6_long_count", nLong, 1);
        repeat (30) applyStimulus(1'b0, 1'b1);
        checkOutput("t6_short_count", nShort, 0);

        $display("[TB] Random phase");
        level = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            level  = ~level;
            segLen = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 35) : $urandom_range(2, 14);
            segEn  = ($urandom_range(0, 9) != 0);
            noisy  = ($urandom_range(0, 4) == 0);
            for (int c = 0; c < segLen; c++) begin
                if (noisy && $urandom_range(0, 3) == 0) applyStimulus(~level, segEn);
                else applyStimulus(level, segEn);
            end
            if ($urandom_range(0, 29) == 0) doReset($urandom_range(1, 3));
        end
        repeat (40) applyStimulus(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
